// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit holding HI/LO.
// One shift-add or restoring shift-subtract step per cycle for DATA_W cycles.
module mul_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wd,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r, div0, sgn_in;
  logic [DATA_W-1:0] m, a_orig, a_mag, b_mag, quo, rem;
  logic [2*DATA_W-1:0] p, p_nxt, prod;
  logic [DATA_W:0] sum, r, diff;
  assign sgn_in = ~op[0];
  assign a_mag = (sgn_in && rs_val[DATA_W-1]) ? -rs_val : rs_val;
  assign b_mag = (sgn_in && rt_val[DATA_W-1]) ? -rt_val : rt_val;
  // Multiply: upper half accumulates, multiplier shifts out of the lower half.
  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  assign sum = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, m} : {(DATA_W+1){1'b0}});
  assign r = {p[2*DATA_W-1:DATA_W], p[DATA_W-1]};
  assign diff = r - {1'b0, m};
  assign p_nxt = is_div ? (diff[DATA_W] ? {r[DATA_W-1:0], p[DATA_W-2:0], 1'b0}
                                        : {diff[DATA_W-1:0], p[DATA_W-2:0], 1'b1})
                        : {sum, p[DATA_W-1:1]};
  assign quo = p_nxt[DATA_W-1:0];
  assign rem = p_nxt[2*DATA_W-1:DATA_W];
  assign prod = neg_q ? -p_nxt : p_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      p      <= '0;
      m      <= '0;
      a_orig <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (state == RUN) begin
      p   <= p_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        if (is_div) begin
          lo <= div0 ? '1 : (neg_q ? -quo : quo);
          hi <= div0 ? a_orig : (neg_r ? -rem : rem);
        end else begin
          {hi, lo} <= prod;
        end
      end
    end else begin
      if (hi_we) hi <= wd;
      if (lo_we) lo <= wd;
      done <= 1'b0;
      if (start) begin
        state  <= RUN;
        busy   <= 1'b1;
        cnt    <= CW'(DATA_W);
        is_div <= op[1];
        neg_q  <= sgn_in & (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
        neg_r  <= sgn_in & rs_val[DATA_W-1];
        div0   <= rt_val == '0;
        a_orig <= rs_val;
        m      <= op[1] ? b_mag : a_mag;
        p      <= {{DATA_W{1'b0}}, op[1] ? a_mag : b_mag};
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit with directed and random ops.
module tb_mul_div_unit;
  logic clk, rst_n, start, hi_we, lo_we, busy, done;
  logic [1:0] op;
  logic [31:0] rs_val, rt_val, wd, hi, lo;
  int checks, fails, busy_cnt;
  logic [63:0] q[$];
  mul_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (o[1] && b == 0) return {a, 32'hFFFF_FFFF};
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] exp);
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("issue_timeout", 64'(busy), 64'd0);
    op = o;
    rs_val = a;
    rt_val = b;
    start = 1'b1;
    if (push) q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        check("result_hilo", {hi, lo}, q.pop_front());
        check("busy_cycles", 64'(busy_cnt), 64'd32);
      end
      busy_cnt = 0;
    end
  end
  initial begin
    logic [1:0] o;
    logic [31:0] a, b;
    int t;
    checks = 0;
    fails = 0;
    busy_cnt = 0;
    start = 0;
    op = 0;
    rs_val = 0;
    rt_val = 0;
    hi_we = 0;
    lo_we = 0;
    wd = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    hi_we = 1;
    wd = 32'h55;
    @(negedge clk);
    hi_we = 0;
    check("mthi_idle", 64'(hi), 64'h55);
    issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1, 64'hFFFF_FFFF_FFFF_FFF1);
    repeat (5) @(negedge clk);
    start = 1;
    op = 2'b01;
    rs_val = 32'd7;
    rt_val = 32'd9;
    @(negedge clk);
    start = 0;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(2'b11, 32'd100, 32'd7, 1, {32'd2, 32'd14});
    issue(2'b11, 32'h1234, 32'd0, 1, {32'h1234, 32'hFFFF_FFFF});
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, {32'h0, 32'h8000_0000});
    issue(2'b10, 32'hFFFF_FFF9, 32'd0, 1, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    issue(2'b01, 32'd5, 32'd5, 1, 64'd25);
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("wait_done", 64'(done), 64'd1);
    start = 1;
    op = 2'b01;
    rs_val = 32'd2;
    rt_val = 32'd3;
    lo_we = 1;
    wd = 32'hAA;
    q.push_back(64'd6);
    @(negedge clk);
    start = 0;
    lo_we = 0;
    check("mtlo_in_done", 64'(lo), 64'hAA);
    check("busy_after_done_start", 64'(busy), 64'd1);
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      issue(o, a, b, 1, model(o, a, b));
    end
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", 64'(q.size()), 64'd0);
    issue(2'b00, 32'd1234, 32'd5678, 0, 64'd0);
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1;
    busy_cnt = 0;
    repeat (40) @(negedge clk);
    check("abort_hilo_after", {hi, lo}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
